// File: rtl/call_control_fsm.sv
// call_control_fsm: front-panel call-control and menu FSM for the telephony node.
// Issues one command at a time to the application layer over a valid/ready handshake.
module call_control_fsm #(
    parameter int unsigned       ADDR_W       = 8,
    parameter logic [ADDR_W-1:0] OWN_ADDR     = '0,
    parameter int unsigned       VOL_W        = 4,
    parameter logic [31:0]       RING_TIMEOUT = 32'd270_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              up,
    input  logic              down,
    input  logic              left,
    input  logic              right,
    input  logic              enter,
    input  logic [ADDR_W-1:0] sw,
    input  logic              init_done,
    input  logic              incoming_call,
    input  logic [ADDR_W-1:0] inc_address,
    input  logic              call_connected,
    input  logic              call_ended,
    input  logic              cmd_ready,
    output logic              cmd_valid,
    output logic [2:0]        cmd,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [2:0]        state,
    output logic [1:0]        menu_item,
    output logic [ADDR_W-1:0] caller_addr,
    output logic [VOL_W-1:0]  volume,
    output logic              vol_adj,
    output logic              vm_enable,
    output logic              on_hold
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INCOMING  = 3'd1,
        ST_OUTGOING  = 3'd2,
        ST_BUSY      = 3'd3,
        ST_CALL_WAIT = 3'd4,
        ST_INIT      = 3'd5
    } state_e;

    localparam logic [2:0] CMD_INIT      = 3'd0;
    localparam logic [2:0] CMD_MAKE_CALL = 3'd1;
    localparam logic [2:0] CMD_ACCEPT    = 3'd2;
    localparam logic [2:0] CMD_REJECT    = 3'd3;
    localparam logic [2:0] CMD_TO_VM     = 3'd4;
    localparam logic [2:0] CMD_END_CALL  = 3'd5;
    localparam logic [2:0] CMD_HOLD      = 3'd6;
    localparam logic [2:0] CMD_RESUME    = 3'd7;

    localparam logic [VOL_W-1:0] VOL_MAX   = {VOL_W{1'b1}};
    localparam logic [VOL_W-1:0] VOL_ONE   = {{(VOL_W-1){1'b0}}, 1'b1};
    localparam logic [VOL_W-1:0] VOL_RESET = {1'b1, {(VOL_W-1){1'b0}}};
    localparam logic [31:0]      RING_LAST = RING_TIMEOUT - 32'd1;

    state_e            state_q, state_d;
    logic [1:0]        menu_q, menu_d;
    logic              cmdValid_q, cmdValid_d;
    logic [2:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] cmdAddr_q, cmdAddr_d;
    logic [ADDR_W-1:0] callerAddr_q, callerAddr_d;
    logic              vmEnable_q, vmEnable_d;
    logic              onHold_q, onHold_d;
    logic              volAdj_q, volAdj_d;
    logic [VOL_W-1:0]  volume_q, volume_d;
    logic [31:0]       timer_q, timer_d;

    logic              stalled, select, ringing, expired, navOk, issue;
    logic [2:0]        issueCmd;
    logic [ADDR_W-1:0] issueAddr;
    logic [1:0]        menuLast;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_INIT;
            menu_q       <= '0;
            cmdValid_q   <= 1'b0;
            cmd_q        <= CMD_INIT;
            cmdAddr_q    <= '0;
            callerAddr_q <= '0;
            vmEnable_q   <= 1'b0;
            onHold_q     <= 1'b0;
            volAdj_q     <= 1'b0;
            volume_q     <= VOL_RESET;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            menu_q       <= menu_d;
            cmdValid_q   <= cmdValid_d;
            cmd_q        <= cmd_d;
            cmdAddr_q    <= cmdAddr_d;
            callerAddr_q <= callerAddr_d;
            vmEnable_q   <= vmEnable_d;
            onHold_q     <= onHold_d;
            volAdj_q     <= volAdj_d;
            volume_q     <= volume_d;
            timer_q      <= timer_d;
        end
    end

    // Priority in every state: external event, then ring timeout, then buttons.
    always_comb begin
        state_d      = state_q;
        menu_d       = menu_q;
        cmdValid_d   = cmdValid_q;
        cmd_d        = cmd_q;
        cmdAddr_d    = cmdAddr_q;
        callerAddr_d = callerAddr_q;
        vmEnable_d   = vmEnable_q;
        onHold_d     = onHold_q;
        volAdj_d     = volAdj_q;
        volume_d     = volume_q;
        timer_d      = timer_q;
        issue        = 1'b0;
        issueCmd     = CMD_INIT;
        issueAddr    = callerAddr_q;
        navOk        = 1'b0;
        menuLast     = 2'd0;

        stalled = cmdValid_q && !cmd_ready;
        select  = right || enter;
        ringing = (state_q == ST_INCOMING) || (state_q == ST_OUTGOING) || (state_q == ST_CALL_WAIT);
        expired = ringing && (timer_q == RING_LAST) && !stalled;

        case (state_q)
            ST_INIT: begin
                if (enter && !stalled) begin
                    issue     = 1'b1;
                    issueCmd  = CMD_INIT;
                    issueAddr = '0;
                end
                if (init_done) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                menuLast = 2'd3;
                if (incoming_call) begin
                    callerAddr_d = inc_address;
                    volAdj_d     = 1'b0;
                    state_d      = ST_INCOMING;
                end else if (!stalled) begin
                    if (volAdj_q && down) begin
                        volume_d = (volume_q == '0) ? volume_q : volume_q - VOL_ONE;
                    end else if (volAdj_q && up) begin
                        volume_d = (volume_q == VOL_MAX) ? volume_q : volume_q + VOL_ONE;
                    end else if (up || down) begin
                        navOk = 1'b1;
                    end else if (left) begin
                        volAdj_d = 1'b0;
                    end else if (select) begin
                        case (menu_q)
                            2'd0: if (sw != OWN_ADDR) begin
                                issue     = 1'b1;
                                issueCmd  = CMD_MAKE_CALL;
                                issueAddr = sw;
                                state_d   = ST_OUTGOING;
                            end
                            2'd1: volAdj_d = 1'b1;
                            2'd2: vmEnable_d = !vmEnable_q;
                            default: ;
                        endcase
                    end
                end
            end
            ST_INCOMING: begin
                menuLast = 2'd2;
                if (expired) begin
                    issue    = 1'b1;
                    issueCmd = vmEnable_q ? CMD_TO_VM : CMD_REJECT;
                    state_d  = ST_IDLE;
                end else if (!stalled) begin
                    if (up || down) begin
                        navOk = 1'b1;
                    end else if (select) begin
                        issue    = 1'b1;
                        issueCmd = (menu_q == 2'd0) ? CMD_ACCEPT :
                                   (menu_q == 2'd1) ? CMD_REJECT : CMD_TO_VM;
                        state_d  = (menu_q == 2'd0) ? ST_BUSY : ST_IDLE;
                    end
                end
            end
            ST_OUTGOING: begin
                if (call_connected) begin
                    state_d = ST_BUSY;
                end else if (expired || (!stalled && select)) begin
                    issue    = 1'b1;
                    issueCmd = CMD_END_CALL;
                    state_d  = ST_IDLE;
                end
            end
            ST_BUSY: begin
                menuLast = 2'd1;
                if (call_ended) begin
                    onHold_d = 1'b0;
                    state_d  = ST_IDLE;
                end else if (incoming_call) begin
                    callerAddr_d = inc_address;
                    state_d      = ST_CALL_WAIT;
                end else if (!stalled) begin
                    if (up || down) begin
                        navOk = 1'b1;
                    end else if (select && menu_q == 2'd0) begin
                        issue    = 1'b1;
                        issueCmd = CMD_END_CALL;
                        onHold_d = 1'b0;
                        state_d  = ST_IDLE;
                    end else if (select) begin
                        issue    = 1'b1;
                        issueCmd = onHold_q ? CMD_RESUME : CMD_HOLD;
                        onHold_d = !onHold_q;
                    end
                end
            end
            ST_CALL_WAIT: begin
                menuLast = 2'd2;
                if (call_ended) begin
                    state_d = ST_INCOMING;
                end else if (expired) begin
                    issue    = 1'b1;
                    issueCmd = vmEnable_q ? CMD_TO_VM : CMD_REJECT;
                    state_d  = ST_BUSY;
                end else if (!stalled) begin
                    if (up || down) begin
                        navOk = 1'b1;
                    end else if (select) begin
                        issue    = 1'b1;
                        issueCmd = (menu_q == 2'd0) ? CMD_ACCEPT :
                                   (menu_q == 2'd1) ? CMD_REJECT : CMD_TO_VM;
                        if (menu_q == 2'd0) onHold_d = 1'b0;
                        state_d  = ST_BUSY;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase

        if (state_d != state_q) begin
            menu_d = '0;
        end else if (navOk && up) begin
            menu_d = (menu_q == 2'd0) ? menuLast : menu_q - 2'd1;
        end else if (navOk && down) begin
            menu_d = (menu_q == menuLast) ? 2'd0 : menu_q + 2'd1;
        end

        // The timer parks on its last count while a command is stalled so it fires afterwards.
        if ((state_d != state_q) || !ringing) begin
            timer_d = '0;
        end else if (timer_q != RING_LAST) begin
            timer_d = timer_q + 32'd1;
        end

        if (issue) begin
            cmdValid_d = 1'b1;
            cmd_d      = issueCmd;
            cmdAddr_d  = issueAddr;
        end else if (cmdValid_q && cmd_ready) begin
            cmdValid_d = 1'b0;
        end
    end

    assign cmd_valid   = cmdValid_q;
    assign cmd         = cmd_q;
    assign cmd_addr    = cmdAddr_q;
    assign state       = state_q;
    assign menu_item   = menu_q;
    assign caller_addr = callerAddr_q;
    assign volume      = volume_q;
    assign vol_adj     = volAdj_q;
    assign vm_enable   = vmEnable_q;
    assign on_hold     = onHold_q;

endmodule
